// File: rtl/feature_frame_buffer_pkg.sv
// Shared constants and types for the input feature path and the dense stages.
package feature_frame_buffer_pkg;

  localparam int unsigned FLOAT_W           = 32;
  localparam int unsigned NB_INPUT_FEATURES = 42;
  localparam int unsigned FRAME_CNT_W       = 16;

  localparam logic [FLOAT_W-1:0] EXP_MASK    = 32'h7F80_0000;
  localparam logic [FLOAT_W-1:0] SCALE_1_256 = 32'h3B80_0000;

  typedef enum logic {
    FILL,
    RESYNC
  } fill_state_e;

  function automatic logic is_inf_nan(input logic [FLOAT_W-1:0] w);
    return (w & EXP_MASK) == EXP_MASK;
  endfunction

endpackage

// File: rtl/feature_bank.sv
// One frame bank: indexed word writes, a full flag and the packed frame bus.
module feature_bank
  import feature_frame_buffer_pkg::*;
#(
  parameter int unsigned FLOAT       = FLOAT_W,
  parameter int unsigned NB_FEATURES = NB_INPUT_FEATURES,
  parameter int unsigned IDX_W       = $clog2(NB_FEATURES)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         wr_en,
  input  logic [IDX_W-1:0]             wr_idx,
  input  logic [FLOAT-1:0]             wr_data,
  input  logic                         set_full,
  input  logic                         clr_full,
  output logic                         full,
  output logic [NB_FEATURES*FLOAT-1:0] rd_bus
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_bus <= '0;
    end else if (wr_en) begin
      rd_bus[int'(wr_idx) * FLOAT +: FLOAT] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full <= 1'b0;
    end else if (set_full) begin
      full <= 1'b1;
    end else if (clr_full) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/feature_frame_buffer.sv
// Ping-pong frame buffer feeding the 42->24 dense layer.
// Optional Inf/NaN scrubbing with sanitize_cnt: FEAT_SANITIZE_EN.
module feature_frame_buffer
  import feature_frame_buffer_pkg::*;
#(
  parameter int unsigned FLOAT       = FLOAT_W,
  parameter int unsigned NB_FEATURES = NB_INPUT_FEATURES,
  parameter int unsigned CNT_W       = FRAME_CNT_W
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [FLOAT-1:0]             in_data,
  input  logic                         in_valid,
  input  logic                         in_last,
  output logic                         in_ready,
  output logic [NB_FEATURES*FLOAT-1:0] frame_out,
  output logic                         frame_valid,
  input  logic                         frame_ack,
  output logic                         frame_err,
  output logic [CNT_W-1:0]             frame_cnt,
  output logic [CNT_W-1:0]             drop_cnt
`ifdef FEAT_SANITIZE_EN
  ,
  output logic [CNT_W-1:0]             sanitize_cnt
`endif
);

  localparam int unsigned      IDX_W    = $clog2(NB_FEATURES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NB_FEATURES - 1);

  fill_state_e                  state, state_nxt;
  logic [IDX_W-1:0]             wr_idx, wr_idx_nxt;
  logic                         wr_ptr, rd_ptr, rdy_q;
  logic [1:0]                   bank_full, bank_wr, bank_set, bank_clr;
  logic [NB_FEATURES*FLOAT-1:0] bank_bus [2];
  logic                         accept, wr_word, complete, drop, ack;
  logic [FLOAT-1:0]             wr_data;

  // rdy_q holds in_ready low through reset and releases it one edge later
  assign in_ready    = rdy_q & ~(&bank_full);
  assign accept      = in_valid & in_ready;
  assign frame_valid = bank_full[rd_ptr];
  assign frame_out   = bank_bus[rd_ptr];
  assign ack         = frame_ack & frame_valid;

`ifdef FEAT_SANITIZE_EN
  logic scrub;
  assign scrub   = is_inf_nan(in_data);
  assign wr_data = scrub ? '0 : in_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sanitize_cnt <= '0;
    end else if (wr_word && scrub) begin
      sanitize_cnt <= sanitize_cnt + 1'b1;
    end
  end
`else
  assign wr_data = in_data;
`endif

  always_comb begin
    state_nxt  = state;
    wr_idx_nxt = wr_idx;
    wr_word    = 1'b0;
    complete   = 1'b0;
    drop       = 1'b0;
    if (accept) begin
      case (state)
        FILL: begin
          wr_word = 1'b1;
          if (wr_idx == LAST_IDX) begin
            wr_idx_nxt = '0;
            if (in_last) begin
              complete = 1'b1;
            end else begin
              drop      = 1'b1;
              state_nxt = RESYNC;
            end
          end else if (in_last) begin
            drop       = 1'b1;
            wr_idx_nxt = '0;
          end else begin
            wr_idx_nxt = wr_idx + 1'b1;
          end
        end
        RESYNC: begin
          if (in_last) begin
            state_nxt  = FILL;
            wr_idx_nxt = '0;
          end
        end
        default: state_nxt = FILL;
      endcase
    end
  end

  always_comb begin
    bank_wr          = '0;
    bank_set         = '0;
    bank_clr         = '0;
    bank_wr[wr_ptr]  = wr_word;
    bank_set[wr_ptr] = complete;
    bank_clr[rd_ptr] = ack;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= FILL;
      wr_idx    <= '0;
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      rdy_q     <= 1'b0;
      frame_err <= 1'b0;
      frame_cnt <= '0;
      drop_cnt  <= '0;
    end else begin
      state     <= state_nxt;
      wr_idx    <= wr_idx_nxt;
      rdy_q     <= 1'b1;
      frame_err <= drop;
      if (complete) begin
        wr_ptr    <= ~wr_ptr;
        frame_cnt <= frame_cnt + 1'b1;
      end
      if (drop) begin
        drop_cnt <= drop_cnt + 1'b1;
      end
      if (ack) begin
        rd_ptr <= ~rd_ptr;
      end
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    feature_bank #(
      .FLOAT       (FLOAT),
      .NB_FEATURES (NB_FEATURES),
      .IDX_W       (IDX_W)
    ) u_bank (
      .clk      (clk),
      .rst_n    (rst_n),
      .wr_en    (bank_wr[b]),
      .wr_idx   (wr_idx),
      .wr_data  (wr_data),
      .set_full (bank_set[b]),
      .clr_full (bank_clr[b]),
      .full     (bank_full[b]),
      .rd_bus   (bank_bus[b])
    );
  end

endmodule
